// File: rtl/riscv_multicycle_core.sv
// Multicycle RV32 integer core: IF/ID/EX/MEM/WB sequencing, host program/data
// load ports, start/done handshake, illegal-instruction halt and saturating counters.
module riscv_multicycle_core #(
    parameter int          XLEN       = 32,
    parameter int          IMEM_DEPTH = 1024,
    parameter int          DMEM_BYTES = 64,
    parameter int          CNT_WIDTH  = 16,
    parameter logic [31:0] EOF_WORD   = 32'hFFFF_FFFF
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    input  logic [31:0]                   imem_wdata,
    input  logic                          dmem_we,
    input  logic [$clog2(DMEM_BYTES)-1:0] dmem_addr,
    input  logic [31:0]                   dmem_wdata,
    output logic [31:0]                   dmem_rdata,
    output logic                          busy,
    output logic                          done,
    output logic                          illegal,
    output logic [CNT_WIDTH-1:0]          clock_count,
    output logic [CNT_WIDTH-1:0]          instr_cnt
);
    localparam int IA = $clog2(IMEM_DEPTH);
    localparam int DA = $clog2(DMEM_BYTES);

    typedef enum logic [2:0] {S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;
    typedef enum logic [2:0] {K_ALU, K_LW, K_SW, K_BR, K_JAL} kind_t;

    state_t          state;
    logic [XLEN-1:0] pc, a_reg, b_reg, alu_out;
    logic [31:0]     ir, mdr;
    logic [XLEN-1:0] rf [32];
    logic [31:0]     imem [IMEM_DEPTH];
    logic [7:0]      dmem [DMEM_BYTES];

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rd, rs1, rs2;
    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    assign imm_i = XLEN'($signed(ir[31:20]));
    assign imm_s = XLEN'($signed({ir[31:25], ir[11:7]}));
    assign imm_b = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
    assign imm_j = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
    assign imm_u = XLEN'($signed({ir[31:12], 12'b0}));

    logic host_en;
    assign host_en = (state == S_IDLE) || (state == S_HALT);

    logic [DA-3:0] hw, cw;
    logic [31:0]   core_word;
    assign hw         = dmem_addr[DA-1:2];
    assign cw         = alu_out[DA-1:2];
    assign dmem_rdata = {dmem[{hw, 2'd0}], dmem[{hw, 2'd1}], dmem[{hw, 2'd2}], dmem[{hw, 2'd3}]};
    assign core_word  = {dmem[{cw, 2'd0}], dmem[{cw, 2'd1}], dmem[{cw, 2'd2}], dmem[{cw, 2'd3}]};

    logic unused_ok;
    assign unused_ok = ^dmem_addr[1:0];

    logic            legal, taken;
    kind_t           kind;
    logic [XLEN-1:0] ex_res, addr_sum;

    always_comb begin
        legal    = 1'b1;
        taken    = 1'b0;
        kind     = K_ALU;
        ex_res   = '0;
        addr_sum = a_reg + ((opcode == 7'b0100011) ? imm_s : imm_i);
        case (opcode)
            7'b0110011: case ({funct7, funct3})
                {7'h00, 3'd0}: ex_res = a_reg + b_reg;
                {7'h20, 3'd0}: ex_res = a_reg - b_reg;
                {7'h01, 3'd0}: ex_res = a_reg * b_reg;
                {7'h00, 3'd2}: ex_res = XLEN'($signed(a_reg) < $signed(b_reg));
                {7'h00, 3'd4}: ex_res = a_reg ^ b_reg;
                {7'h00, 3'd6}: ex_res = a_reg | b_reg;
                {7'h00, 3'd7}: ex_res = a_reg & b_reg;
                default:       legal  = 1'b0;
            endcase
            7'b0010011: case (funct3)
                3'd0:    ex_res = a_reg + imm_i;
                3'd2:    ex_res = XLEN'($signed(a_reg) < $signed(imm_i));
                3'd4:    ex_res = a_reg ^ imm_i;
                3'd6:    ex_res = a_reg | imm_i;
                3'd7:    ex_res = a_reg & imm_i;
                default: legal  = 1'b0;
            endcase
            7'b0110111: ex_res = imm_u;
            7'b0000011, 7'b0100011: begin
                kind   = (opcode == 7'b0000011) ? K_LW : K_SW;
                legal  = (funct3 == 3'd2);
                // Data addresses wrap inside the small data memory and are word aligned.
                ex_res = XLEN'({addr_sum[DA-1:2], 2'b00});
            end
            7'b1100011: begin
                kind = K_BR;
                case (funct3)
                    3'd0:    taken = (a_reg == b_reg);
                    3'd1:    taken = (a_reg != b_reg);
                    3'd4:    taken = ($signed(a_reg) <  $signed(b_reg));
                    3'd5:    taken = ($signed(a_reg) >= $signed(b_reg));
                    default: legal = 1'b0;
                endcase
            end
            7'b1101111: kind  = K_JAL;
            default:    legal = 1'b0;
        endcase
    end

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c, input logic [1:0] n);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, c} + {{(CNT_WIDTH-1){1'b0}}, n};
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
            clock_count <= '0;
            instr_cnt   <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALT: if (start) begin
                    pc          <= '0;
                    clock_count <= '0;
                    instr_cnt   <= '0;
                    done        <= 1'b0;
                    illegal     <= 1'b0;
                    busy        <= 1'b1;
                    state       <= S_IF;
                end
                S_IF: begin
                    ir    <= imem[pc[IA+1:2]];
                    pc    <= pc + XLEN'(4);
                    state <= S_ID;
                end
                S_ID: if (ir == EOF_WORD) begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_HALT;
                end else begin
                    a_reg       <= (rs1 == 5'd0) ? '0 : rf[rs1];
                    b_reg       <= (rs2 == 5'd0) ? '0 : rf[rs2];
                    alu_out     <= pc - XLEN'(4) + imm_b;
                    // IF and ID are charged here so the end marker costs no cycles.
                    clock_count <= sat_inc(clock_count, 2'd2);
                    state       <= S_EX;
                end
                S_EX: begin
                    clock_count <= sat_inc(clock_count, 2'd1);
                    if (!legal) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        illegal <= 1'b1;
                        state   <= S_HALT;
                    end else begin
                        instr_cnt <= sat_inc(instr_cnt, 2'd1);
                        case (kind)
                            K_BR: begin
                                if (taken) pc <= alu_out;
                                state <= S_IF;
                            end
                            K_JAL: begin
                                if (rd != 5'd0) rf[rd] <= pc;
                                pc    <= pc - XLEN'(4) + imm_j;
                                state <= S_IF;
                            end
                            default: begin
                                alu_out <= ex_res;
                                state   <= S_MEM;
                            end
                        endcase
                    end
                end
                S_MEM: begin
                    clock_count <= sat_inc(clock_count, 2'd1);
                    case (kind)
                        K_LW: begin
                            mdr   <= core_word;
                            state <= S_WB;
                        end
                        K_SW: state <= S_IF;
                        default: begin
                            if (rd != 5'd0) rf[rd] <= alu_out;
                            state <= S_IF;
                        end
                    endcase
                end
                S_WB: begin
                    clock_count <= sat_inc(clock_count, 2'd1);
                    if (rd != 5'd0) rf[rd] <= XLEN'($signed(mdr));
                    state <= S_IF;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset && host_en && imem_we) imem[imem_addr] <= imem_wdata;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            if (host_en && dmem_we) begin
                dmem[{hw, 2'd0}] <= dmem_wdata[31:24];
                dmem[{hw, 2'd1}] <= dmem_wdata[23:16];
                dmem[{hw, 2'd2}] <= dmem_wdata[15:8];
                dmem[{hw, 2'd3}] <= dmem_wdata[7:0];
            end else if (state == S_MEM && kind == K_SW) begin
                dmem[{cw, 2'd0}] <= b_reg[31:24];
                dmem[{cw, 2'd1}] <= b_reg[23:16];
                dmem[{cw, 2'd2}] <= b_reg[15:8];
                dmem[{cw, 2'd3}] <= b_reg[7:0];
            end
        end
    end
endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Bench for riscv_multicycle_core: directed programs plus random programs checked
// against an instruction-level reference model; a CNT_WIDTH=4 twin checks saturation.
module tb_riscv_multicycle_core;
    localparam logic [31:0] EOF_W = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset, start, imem_we, dmem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata, dmem_wdata, dmem_rdata, s_dmem_rdata;
    logic [5:0]  dmem_addr;
    logic        busy, done, illegal, s_busy, s_done, s_illegal;
    logic [15:0] clock_count, instr_cnt;
    logic [3:0]  s_clock_count, s_instr_cnt;
    int checks = 0, errors = 0;

    always #10 clk = ~clk;

    riscv_multicycle_core dut (
        .CLOCK_50(clk), .reset(reset), .start(start), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .busy(busy), .done(done), .illegal(illegal),
        .clock_count(clock_count), .instr_cnt(instr_cnt));

    riscv_multicycle_core #(.CNT_WIDTH(4)) dut_sat (
        .CLOCK_50(clk), .reset(reset), .start(start), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(s_dmem_rdata), .busy(s_busy), .done(s_done), .illegal(s_illegal),
        .clock_count(s_clock_count), .instr_cnt(s_instr_cnt));

    // Reference machine state
    logic [31:0] m_imem [1024];
    logic [31:0] m_reg  [32];
    logic [31:0] m_dmem [16];
    logic [31:0] prog [$];

    function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] i_op(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1, input int imm);
        logic [31:0] v = imm;
        return {v[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input int imm);
        return i_op(7'h13, 3'd0, rd, rs1, imm);
    endfunction
    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input int imm);
        return i_op(7'h03, 3'd2, rd, rs1, imm);
    endfunction
    function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input int imm);
        logic [31:0] v = imm;
        return {v[11:5], rs2, rs1, 3'd2, v[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] br(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2, input int off);
        logic [31:0] v = off;
        return {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], 7'h63};
    endfunction
    function automatic logic [31:0] jal(input logic [4:0] rd, input int off);
        logic [31:0] v = off;
        return {v[20], v[10:1], v[11], v[19:12], rd, 7'h6f};
    endfunction
    function automatic logic [31:0] lui(input logic [4:0] rd, input logic [19:0] imm20);
        return {imm20, rd, 7'h37};
    endfunction

    // Executes the loaded program instruction by instruction from address 0.
    task automatic model_run(output int ic, output int cc, output bit ill);
        logic [31:0] pc, w, a, b, res, nxt, t, ii, si, bi, ji;
        int lat; bit wr, c;
        pc = 0; ic = 0; cc = 0; ill = 0;
        for (int s = 0; s < 4000; s++) begin
            w = m_imem[pc[11:2]];
            if (w == EOF_W) return;
            a  = m_reg[w[19:15]];
            b  = m_reg[w[24:20]];
            ii = {{20{w[31]}}, w[31:20]};
            si = {{20{w[31]}}, w[31:25], w[11:7]};
            bi = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            ji = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            nxt = pc + 4; lat = 4; wr = 1; res = 0; c = 0;
            case (w[6:0])
                7'h33: case ({w[31:25], w[14:12]})
                    {7'h00, 3'd0}: res = a + b;
                    {7'h20, 3'd0}: res = a - b;
                    {7'h01, 3'd0}: res = a * b;
                    {7'h00, 3'd2}: res = ($signed(a) < $signed(b)) ? 1 : 0;
                    {7'h00, 3'd4}: res = a ^ b;
                    {7'h00, 3'd6}: res = a | b;
                    {7'h00, 3'd7}: res = a & b;
                    default: ill = 1;
                endcase
                7'h13: case (w[14:12])
                    3'd0: res = a + ii;
                    3'd2: res = ($signed(a) < $signed(ii)) ? 1 : 0;
                    3'd4: res = a ^ ii;
                    3'd6: res = a | ii;
                    3'd7: res = a & ii;
                    default: ill = 1;
                endcase
                7'h37: res = {w[31:12], 12'h000};
                7'h03: if (w[14:12] == 3'd2) begin t = a + ii; res = m_dmem[t[5:2]]; lat = 5; end else ill = 1;
                7'h23: if (w[14:12] == 3'd2) begin t = a + si; m_dmem[t[5:2]] = b; wr = 0; end else ill = 1;
                7'h63: begin
                    case (w[14:12])
                        3'd0: c = (a == b);
                        3'd1: c = (a != b);
                        3'd4: c = ($signed(a) < $signed(b));
                        3'd5: c = ($signed(a) >= $signed(b));
                        default: ill = 1;
                    endcase
                    if (c) nxt = pc + bi;
                    lat = 3; wr = 0;
                end
                7'h6f: begin res = pc + 4; nxt = pc + ji; lat = 3; end
                default: ill = 1;
            endcase
            if (ill) return;
            ic++; cc += lat;
            if (wr && w[11:7] != 0) m_reg[w[11:7]] = res;
            pc = nxt;
        end
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0;
        for (int i = 0; i < 32; i++) m_reg[i] = 0;
    endtask

    task automatic host_dmem(input int addr, input logic [31:0] d);
        @(negedge clk); dmem_we = 1; dmem_addr = addr[5:0]; dmem_wdata = d;
        @(negedge clk); dmem_we = 0;
        m_dmem[addr[5:2]] = d;
    endtask

    task automatic load_prog();
        prog.push_back(EOF_W);
        foreach (prog[i]) begin
            @(negedge clk); imem_we = 1; imem_addr = i[9:0]; imem_wdata = prog[i];
            m_imem[i] = prog[i];
        end
        @(negedge clk); imem_we = 0;
        prog.delete();
    endtask

    task automatic read_word(input int addr, output logic [31:0] d);
        @(negedge clk); dmem_addr = addr[5:0];
        #1 d = dmem_rdata;
    endtask

    task automatic run_core(output bit ok, output logic early_ill, output int eic, output int ecc, output bit eill);
        @(negedge clk); start = 1;
        @(negedge clk); start = 0; early_ill = illegal;
        ok = 0;
        for (int n = 0; n < 4000; n++) begin
            if (done) begin ok = 1; break; end
            @(negedge clk);
        end
        model_run(eic, ecc, eill);
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0)         begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        if (illegal !== 1'b0)      begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal); end
        if (clock_count !== 16'd0) begin errors++; $display("FAIL reset_cc: got %0d want 0", clock_count); end
        if (instr_cnt !== 16'd0)   begin errors++; $display("FAIL reset_ic: got %0d want 0", instr_cnt); end
    endtask

    task automatic test_arith();
        bit ok, eill; logic ei; int eic, ecc; logic [31:0] d;
        prog = '{addi(1, 0, -5), addi(2, 0, 3), r_op(7'h00, 3'd0, 3, 1, 2),
                 r_op(7'h20, 3'd0, 4, 2, 1), r_op(7'h01, 3'd0, 5, 1, 2)};
        load_prog();
        run_core(ok, ei, eic, ecc, eill);
        checks += 3;
        if (!ok || done !== 1'b1) begin errors++; $display("FAIL arith_done: got %b want 1", done); end
        if (instr_cnt !== 16'd5)   begin errors++; $display("FAIL arith_ic: got %0d want 5", instr_cnt); end
        if (clock_count !== 16'd20) begin errors++; $display("FAIL arith_cc: got %0d want 20", clock_count); end
        // Registers survive a restart, so a second program exposes them.
        prog = '{sw(3, 0, 0), sw(4, 0, 4), sw(5, 0, 8)};
        load_prog();
        run_core(ok, ei, eic, ecc, eill);
        checks += 3;
        read_word(0, d); if (d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL arith_x3: got %h want fffffffe", d); end
        read_word(4, d); if (d !== 32'd8)         begin errors++; $display("FAIL arith_x4: got %h want 8", d); end
        read_word(8, d); if (d !== 32'hFFFF_FFF1) begin errors++; $display("FAIL arith_x5: got %h want fffffff1", d); end
    endtask

    task automatic test_lwsw();
        bit ok, eill; logic ei; int eic, ecc; logic [31:0] d;
        host_dmem(8, 32'h1234_5678);
        prog = '{lw(6, 0, 8), addi(6, 6, 1), sw(6, 0, 12)};
        load_prog();
        run_core(ok, ei, eic, ecc, eill);
        read_word(12, d);
        checks += 5;
        if (!ok || d !== 32'h1234_5679) begin errors++; $display("FAIL lwsw_word: got %h want 12345679", d); end
        if (d[31:24] !== 8'h12) begin errors++; $display("FAIL lwsw_byte12: got %h want 12", d[31:24]); end
        if (d[7:0] !== 8'h79)   begin errors++; $display("FAIL lwsw_byte15: got %h want 79", d[7:0]); end
        if (clock_count !== 16'd13) begin errors++; $display("FAIL lwsw_cc: got %0d want 13", clock_count); end
        if (instr_cnt !== 16'd3)    begin errors++; $display("FAIL lwsw_ic: got %0d want 3", instr_cnt); end
    endtask

    task automatic test_branch();
        bit ok, eill; logic ei; int eic, ecc; logic [31:0] d;
        prog = '{addi(1, 0, 3), addi(1, 1, -1), br(3'd4, 0, 1, -4)};
        load_prog();
        run_core(ok, ei, eic, ecc, eill);
        checks += 2;
        if (!ok || instr_cnt !== 16'd7) begin errors++; $display("FAIL loop_ic: got %0d want 7", instr_cnt); end
        if (clock_count !== 16'd25)     begin errors++; $display("FAIL loop_cc: got %0d want 25", clock_count); end
        prog = '{sw(1, 0, 16)};
        load_prog();
        run_core(ok, ei, eic, ecc, eill);
        read_word(16, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL loop_x1: got %h want 0", d); end
        prog = '{addi(1, 0, 5), addi(2, 0, -3), addi(3, 0, 5), addi(10, 0, 0),
                 br(3'd5, 1, 2, 8), addi(10, 10, 1), br(3'd5, 2, 1, 8), addi(10, 10, 2),
                 br(3'd0, 1, 3, 8), addi(10, 10, 4), br(3'd0, 1, 2, 8), addi(10, 10, 8),
                 br(3'd1, 1, 2, 8), addi(10, 10, 16), br(3'd1, 1, 3, 8), addi(10, 10, 32),
                 jal(7, 8), addi(10, 10, 64), sw(10, 0, 20), sw(7, 0, 24)};
        load_prog();
        run_core(ok, ei, eic, ecc, eill);
        checks += 5;
        read_word(20, d); if (d !== 32'd42) begin errors++; $display("FAIL br_mask: got %h want 2a", d); end
        read_word(24, d); if (d !== 32'd68) begin errors++; $display("FAIL jal_link: got %h want 44", d); end
        if (!ok || instr_cnt !== 16'd16) begin errors++; $display("FAIL br_ic: got %0d want 16", instr_cnt); end
        if (clock_count !== 16'd57)      begin errors++; $display("FAIL br_cc: got %0d want 57", clock_count); end
        if (clock_count !== 16'(ecc))    begin errors++; $display("FAIL br_cc_model: got %0d want %0d", clock_count, ecc); end
    endtask

    task automatic test_illegal();
        bit ok, eill; logic ei; int eic, ecc; logic [31:0] d;
        host_dmem(0, 32'hDEAD_BEEF);
        prog = '{addi(0, 0, 7), 32'h0000_0000};
        load_prog();
        run_core(ok, ei, eic, ecc, eill);
        checks += 3;
        if (!ok || done !== 1'b1)       begin errors++; $display("FAIL ill_done: got %b want 1", done); end
        if (illegal !== 1'(eill) || illegal !== 1'b1) begin errors++; $display("FAIL ill_flag: got %b want 1", illegal); end
        if (instr_cnt !== 16'd1)        begin errors++; $display("FAIL ill_ic: got %0d want 1", instr_cnt); end
        prog = '{addi(0, 0, 7), sw(0, 0, 0)};
        load_prog();
        run_core(ok, ei, eic, ecc, eill);
        read_word(0, d);
        checks += 4;
        if (ei !== 1'b0)                begin errors++; $display("FAIL ill_clear: got %b want 0", ei); end
        if (!ok || illegal !== 1'b0)    begin errors++; $display("FAIL ill_rerun: got %b want 0", illegal); end
        if (instr_cnt !== 16'd2)        begin errors++; $display("FAIL ill_restart_ic: got %0d want 2", instr_cnt); end
        if (d !== 32'd0)                begin errors++; $display("FAIL x0_zero: got %h want 0", d); end
    endtask

    task automatic test_mid_reset();
        bit ok, eill; logic ei; int eic, ecc; logic [31:0] d;
        host_dmem(16, 32'hAAAA_5555);
        host_dmem(20, 32'h1111_1111);
        host_dmem(24, 32'hFFFF_FFFF);
        prog = '{lw(6, 0, 16), sw(6, 0, 20)};
        load_prog();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        repeat (3) @(negedge clk);
        reset = 1;
        @(negedge clk); reset = 0;
        for (int i = 0; i < 32; i++) m_reg[i] = 0;
        checks += 5;
        if (busy !== 1'b0)         begin errors++; $display("FAIL mrst_busy: got %b want 0", busy); end
        if (done !== 1'b0)         begin errors++; $display("FAIL mrst_done: got %b want 0", done); end
        if (illegal !== 1'b0)      begin errors++; $display("FAIL mrst_illegal: got %b want 0", illegal); end
        if (clock_count !== 16'd0) begin errors++; $display("FAIL mrst_cc: got %0d want 0", clock_count); end
        if (instr_cnt !== 16'd0)   begin errors++; $display("FAIL mrst_ic: got %0d want 0", instr_cnt); end
        prog = '{sw(6, 0, 24)};
        load_prog();
        run_core(ok, ei, eic, ecc, eill);
        checks += 3;
        read_word(24, d); if (!ok || d !== 32'd0) begin errors++; $display("FAIL mrst_rd: got %h want 0", d); end
        read_word(20, d); if (d !== 32'h1111_1111) begin errors++; $display("FAIL mrst_nowrite: got %h want 11111111", d); end
        if (clock_count !== 16'd4) begin errors++; $display("FAIL mrst_pc0_cc: got %0d want 4", clock_count); end
    endtask

    task automatic test_saturation();
        bit ok, eill; logic ei; int eic, ecc;
        for (int i = 0; i < 20; i++) prog.push_back(addi(1, 1, 1));
        load_prog();
        run_core(ok, ei, eic, ecc, eill);
        checks += 5;
        if (!ok || s_done !== 1'b1)   begin errors++; $display("FAIL sat_done: got %b want 1", s_done); end
        if (s_clock_count !== 4'd15)  begin errors++; $display("FAIL sat_cc: got %0d want 15", s_clock_count); end
        if (s_instr_cnt !== 4'd15)    begin errors++; $display("FAIL sat_ic: got %0d want 15", s_instr_cnt); end
        if (instr_cnt !== 16'd20)     begin errors++; $display("FAIL wide_ic: got %0d want 20", instr_cnt); end
        if (clock_count !== 16'd80)   begin errors++; $display("FAIL wide_cc: got %0d want 80", clock_count); end
    endtask

    task automatic test_random();
        bit ok, eill; logic ei; int eic, ecc, k; logic [31:0] d;
        logic [4:0] rd, ra, rb;
        logic [2:0] f3s [5] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd7};
        logic [2:0] bf3 [4] = '{3'd0, 3'd1, 3'd4, 3'd5};
        for (int it = 0; it < 6; it++) begin
            for (int n = 0; n < 14; n++) begin
                rd = 5'($urandom_range(0, 7)); ra = 5'($urandom_range(0, 7)); rb = 5'($urandom_range(0, 7));
                k = $urandom_range(0, 9);
                case (k)
                    0: prog.push_back(r_op(7'h00, 3'd0, rd, ra, rb));
                    1: prog.push_back(r_op(7'h20, 3'd0, rd, ra, rb));
                    2: prog.push_back(r_op(7'h01, 3'd0, rd, ra, rb));
                    3: prog.push_back(r_op(7'h00, f3s[$urandom_range(1, 4)], rd, ra, rb));
                    4, 5: prog.push_back(i_op(7'h13, f3s[$urandom_range(0, 4)], rd, ra, int'($urandom_range(0, 4095)) - 2048));
                    6: prog.push_back(lui(rd, 20'($urandom)));
                    7: prog.push_back(lw(rd, ra, int'($urandom_range(0, 4095)) - 2048));
                    8: prog.push_back(sw(rb, ra, int'($urandom_range(0, 4095)) - 2048));
                    default: if ($urandom_range(0, 3) == 0) prog.push_back(jal(rd, 8));
                             else prog.push_back(br(bf3[$urandom_range(0, 3)], ra, rb, 8));
                endcase
            end
            for (int r = 1; r < 8; r++) prog.push_back(sw(5'(r), 0, 28 + 4 * r));
            load_prog();
            run_core(ok, ei, eic, ecc, eill);
            checks += 3;
            if (!ok || done !== 1'b1 || illegal !== 1'b0) begin errors++; $display("FAIL rnd%0d_halt: got done=%b ill=%b want 1/0", it, done, illegal); end
            if (instr_cnt !== 16'(eic))   begin errors++; $display("FAIL rnd%0d_ic: got %0d want %0d", it, instr_cnt, eic); end
            if (clock_count !== 16'(ecc)) begin errors++; $display("FAIL rnd%0d_cc: got %0d want %0d", it, clock_count, ecc); end
            for (int wi = 0; wi < 16; wi++) begin
                read_word(4 * wi, d);
                checks++;
                if (d !== m_dmem[wi]) begin errors++; $display("FAIL rnd%0d_dmem%0d: got %h want %h", it, wi, d, m_dmem[wi]); end
            end
        end
    endtask

    initial begin
        reset = 1; start = 0; imem_we = 0; dmem_we = 0;
        imem_addr = '0; imem_wdata = '0; dmem_addr = '0; dmem_wdata = '0;
        for (int i = 0; i < 32; i++) m_reg[i] = 0;
        repeat (2) @(negedge clk);
        test_reset();
        for (int i = 0; i < 16; i++) host_dmem(4 * i, 32'h0);
        test_arith();
        test_lwsw();
        test_branch();
        test_illegal();
        test_mid_reset();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
